// File: rtl/qdec_arith_dec.sv
// CABAC arithmetic decoding engine: context, bypass and terminate bins fed from an RBSP byte stream,
// with a post-terminate raw-bit mode for trailing bits.
module qdec_arith_dec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arithInit,
  input  logic       dec_run,
  output logic       dec_rdy,
  input  logic       EPMode,
  input  logic       term_mode,
  input  logic [6:0] ctxState,
  input  logic       mps,
  input  logic       ctxState_vld,
  output logic       ctxState_rdy,
  output logic [6:0] ctxStateUpdate,
  output logic       ctxStateUpdate_vld,
  input  logic       ctxStateUpdate_rdy,
  output logic       ruiBin,
  output logic       ruiBin_vld,
  output logic       ruiBin_bytealign,
  input  logic [7:0] bs_data,
  input  logic       bs_vld,
  output logic       bs_rdy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_FLUSHED = 2'd3;

  // Row packed as {q0, q1, q2, q3}
  function automatic logic [31:0] lps_tab(input logic [5:0] p);
    logic [31:0] r;
    case (p)
      6'd0:  r = {8'd128, 8'd176, 8'd208, 8'd240};  6'd1:  r = {8'd128, 8'd167, 8'd197, 8'd227};
      6'd2:  r = {8'd128, 8'd158, 8'd187, 8'd216};  6'd3:  r = {8'd123, 8'd150, 8'd178, 8'd205};
      6'd4:  r = {8'd116, 8'd142, 8'd169, 8'd195};  6'd5:  r = {8'd111, 8'd135, 8'd160, 8'd185};
      6'd6:  r = {8'd105, 8'd128, 8'd152, 8'd175};  6'd7:  r = {8'd100, 8'd122, 8'd144, 8'd166};
      6'd8:  r = {8'd95,  8'd116, 8'd137, 8'd158};  6'd9:  r = {8'd90,  8'd110, 8'd130, 8'd150};
      6'd10: r = {8'd85,  8'd104, 8'd123, 8'd142};  6'd11: r = {8'd81,  8'd99,  8'd117, 8'd135};
      6'd12: r = {8'd77,  8'd94,  8'd111, 8'd128};  6'd13: r = {8'd73,  8'd89,  8'd105, 8'd122};
      6'd14: r = {8'd69,  8'd85,  8'd100, 8'd116};  6'd15: r = {8'd66,  8'd80,  8'd95,  8'd110};
      6'd16: r = {8'd62,  8'd76,  8'd90,  8'd104};  6'd17: r = {8'd59,  8'd72,  8'd86,  8'd99};
      6'd18: r = {8'd56,  8'd69,  8'd81,  8'd94};   6'd19: r = {8'd53,  8'd65,  8'd77,  8'd89};
      6'd20: r = {8'd51,  8'd62,  8'd73,  8'd85};   6'd21: r = {8'd48,  8'd59,  8'd69,  8'd80};
      6'd22: r = {8'd46,  8'd56,  8'd66,  8'd76};   6'd23: r = {8'd43,  8'd53,  8'd63,  8'd72};
      6'd24: r = {8'd41,  8'd50,  8'd59,  8'd69};   6'd25: r = {8'd39,  8'd48,  8'd56,  8'd65};
      6'd26: r = {8'd37,  8'd45,  8'd54,  8'd62};   6'd27: r = {8'd35,  8'd43,  8'd51,  8'd59};
      6'd28: r = {8'd33,  8'd41,  8'd48,  8'd56};   6'd29: r = {8'd32,  8'd39,  8'd46,  8'd53};
      6'd30: r = {8'd30,  8'd37,  8'd43,  8'd50};   6'd31: r = {8'd29,  8'd35,  8'd41,  8'd48};
      6'd32: r = {8'd27,  8'd33,  8'd39,  8'd45};   6'd33: r = {8'd26,  8'd31,  8'd37,  8'd43};
      6'd34: r = {8'd24,  8'd30,  8'd35,  8'd41};   6'd35: r = {8'd23,  8'd28,  8'd33,  8'd39};
      6'd36: r = {8'd22,  8'd27,  8'd32,  8'd37};   6'd37: r = {8'd21,  8'd26,  8'd30,  8'd35};
      6'd38: r = {8'd20,  8'd24,  8'd29,  8'd33};   6'd39: r = {8'd19,  8'd23,  8'd27,  8'd31};
      6'd40: r = {8'd18,  8'd22,  8'd26,  8'd30};   6'd41: r = {8'd17,  8'd21,  8'd25,  8'd28};
      6'd42: r = {8'd16,  8'd20,  8'd23,  8'd27};   6'd43: r = {8'd15,  8'd19,  8'd22,  8'd25};
      6'd44: r = {8'd14,  8'd18,  8'd21,  8'd24};   6'd45: r = {8'd14,  8'd17,  8'd20,  8'd23};
      6'd46: r = {8'd13,  8'd16,  8'd19,  8'd22};   6'd47: r = {8'd12,  8'd15,  8'd18,  8'd21};
      6'd48: r = {8'd12,  8'd14,  8'd17,  8'd20};   6'd49: r = {8'd11,  8'd14,  8'd16,  8'd19};
      6'd50: r = {8'd11,  8'd13,  8'd15,  8'd18};   6'd51: r = {8'd10,  8'd12,  8'd15,  8'd17};
      6'd52: r = {8'd10,  8'd12,  8'd14,  8'd16};   6'd53: r = {8'd9,   8'd11,  8'd13,  8'd15};
      6'd54: r = {8'd9,   8'd11,  8'd12,  8'd14};   6'd55: r = {8'd8,   8'd10,  8'd12,  8'd14};
      6'd56: r = {8'd8,   8'd9,   8'd11,  8'd13};   6'd57: r = {8'd7,   8'd9,   8'd11,  8'd12};
      6'd58: r = {8'd7,   8'd9,   8'd10,  8'd12};   6'd59: r = {8'd7,   8'd8,   8'd10,  8'd11};
      6'd60: r = {8'd6,   8'd8,   8'd9,   8'd11};   6'd61: r = {8'd6,   8'd7,   8'd9,   8'd10};
      default: r = {8'd6, 8'd7, 8'd8, 8'd9};
    endcase
    return r;
  endfunction

  function automatic logic [5:0] trans_lps(input logic [5:0] p);
    logic [5:0] t;
    case (p)
      6'd0, 6'd1:               t = 6'd0;
      6'd2:                     t = 6'd1;
      6'd3, 6'd4:               t = 6'd2;
      6'd5, 6'd6:               t = 6'd4;
      6'd7:                     t = 6'd5;
      6'd8:                     t = 6'd6;
      6'd9:                     t = 6'd7;
      6'd10:                    t = 6'd8;
      6'd11, 6'd12:             t = 6'd9;
      6'd13, 6'd14:             t = 6'd11;
      6'd15:                    t = 6'd12;
      6'd16, 6'd17:             t = 6'd13;
      6'd18, 6'd19:             t = 6'd15;
      6'd20, 6'd21:             t = 6'd16;
      6'd22, 6'd23:             t = 6'd18;
      6'd24, 6'd25:             t = 6'd19;
      6'd26, 6'd27:             t = 6'd21;
      6'd28, 6'd29:             t = 6'd22;
      6'd30:                    t = 6'd23;
      6'd31, 6'd32:             t = 6'd24;
      6'd33:                    t = 6'd25;
      6'd34, 6'd35:             t = 6'd26;
      6'd36, 6'd37:             t = 6'd27;
      6'd38:                    t = 6'd28;
      6'd39, 6'd40:             t = 6'd29;
      6'd41, 6'd42, 6'd43:      t = 6'd30;
      6'd44:                    t = 6'd31;
      6'd45, 6'd46:             t = 6'd32;
      6'd47, 6'd48, 6'd49:      t = 6'd33;
      6'd50, 6'd51:             t = 6'd34;
      6'd52, 6'd53, 6'd54:      t = 6'd35;
      6'd55, 6'd56, 6'd57:      t = 6'd36;
      6'd58, 6'd59, 6'd60:      t = 6'd37;
      default:                  t = 6'd38;
    endcase
    return t;
  endfunction

  function automatic logic [2:0] renorm_shift(input logic [8:0] r);
    logic [2:0] n;
    if (r[8])      n = 3'd0;
    else if (r[7]) n = 3'd1;
    else if (r[6]) n = 3'd2;
    else if (r[5]) n = 3'd3;
    else if (r[4]) n = 3'd4;
    else if (r[3]) n = 3'd5;
    else           n = 3'd6;
    return n;
  endfunction

  logic [1:0]  state, state_n;
  logic [15:0] bitbuf, bitbuf_n, buf_c;
  logic [4:0]  count, count_n, cnt_c;
  logic [2:0]  bitpos, bitpos_n;
  logic [8:0]  ivl_range, range_n, ivl_offset, offset_n;
  logic        flush_first, flush_first_n;
  logic        bin_n, align_n, bin_vld_n, upd_vld_n;
  logic [6:0]  upd_n;

  logic        stall, accept, take_byte, norm;
  logic [5:0]  p_eff, new_p;
  logic        new_mps;
  logic [31:0] lps_row;
  logic [7:0]  r_lps;
  logic [8:0]  r_mps, r_dec, o_dec;
  logic [9:0]  off2, byp_diff;
  logic [14:0] ren_tmp;
  logic [2:0]  rn;
  logic [3:0]  nsh;
  logic        unused_bit6;

  assign unused_bit6  = ctxState[6];
  assign stall        = ctxStateUpdate_vld & ~ctxStateUpdate_rdy;
  assign dec_rdy      = (state == S_RUN || state == S_FLUSHED) && !arithInit && count >= 5'd8 && !stall;
  assign ctxState_rdy = dec_rdy;
  assign bs_rdy       = (state != S_IDLE) && !arithInit && count <= 5'd8;
  assign accept       = dec_rdy & dec_run & (term_mode | EPMode | ctxState_vld);
  assign take_byte    = bs_vld & bs_rdy;
  assign p_eff        = (ctxState[5:0] > 6'd62) ? 6'd62 : ctxState[5:0];
  assign lps_row      = lps_tab(p_eff);
  assign r_mps        = ivl_range - {1'b0, r_lps};
  assign off2         = {ivl_offset, bitbuf[15]};
  assign byp_diff     = off2 - {1'b0, ivl_range};

  always_comb begin
    case (ivl_range[7:6])
      2'd0:    r_lps = lps_row[31:24];
      2'd1:    r_lps = lps_row[23:16];
      2'd2:    r_lps = lps_row[15:8];
      default: r_lps = lps_row[7:0];
    endcase
  end

  always_comb begin
    state_n       = state;
    range_n       = ivl_range;
    offset_n      = ivl_offset;
    bitpos_n      = bitpos;
    flush_first_n = flush_first;
    bin_n         = ruiBin;
    align_n       = ruiBin_bytealign;
    bin_vld_n     = 1'b0;
    upd_n         = ctxStateUpdate;
    upd_vld_n     = ctxStateUpdate_vld & ~ctxStateUpdate_rdy;
    nsh           = 4'd0;
    norm          = 1'b0;
    r_dec         = ivl_range;
    o_dec         = ivl_offset;
    new_p         = p_eff;
    new_mps       = mps;
    rn            = 3'd0;
    ren_tmp       = '0;

    case (state)
      S_LOAD: begin
        if (count >= 5'd9) begin
          offset_n = bitbuf[15:7];
          range_n  = 9'd510;
          nsh      = 4'd9;
          bitpos_n = bitpos + 3'd1;
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          bin_vld_n = 1'b1;
          if (term_mode) begin
            r_dec = ivl_range - 9'd2;
            if (ivl_offset >= r_dec) begin
              bin_n         = 1'b1;
              range_n       = r_dec;
              state_n       = S_FLUSHED;
              flush_first_n = 1'b1;
            end else begin
              bin_n = 1'b0;
              norm  = 1'b1;
            end
          end else if (EPMode) begin
            nsh = 4'd1;
            if (off2 >= {1'b0, ivl_range}) begin
              bin_n    = 1'b1;
              offset_n = byp_diff[8:0];
            end else begin
              bin_n    = 1'b0;
              offset_n = off2[8:0];
            end
          end else begin
            if (ivl_offset >= r_mps) begin
              bin_n   = ~mps;
              o_dec   = ivl_offset - r_mps;
              r_dec   = {1'b0, r_lps};
              new_mps = mps ^ (p_eff == 6'd0);
              new_p   = trans_lps(p_eff);
            end else begin
              bin_n   = mps;
              r_dec   = r_mps;
              new_p   = (p_eff == 6'd62) ? 6'd62 : p_eff + 6'd1;
            end
            norm      = 1'b1;
            upd_n     = {new_p, new_mps};
            upd_vld_n = 1'b1;
          end
          // Renormalisation pulls up to 6 fresh bits from the top of the buffer in the decision cycle
          if (norm) begin
            rn       = renorm_shift(r_dec);
            range_n  = r_dec << rn;
            ren_tmp  = {o_dec, bitbuf[15:10]} >> (3'd6 - rn);
            offset_n = ren_tmp[8:0];
            nsh      = {1'b0, rn};
          end
          bitpos_n = bitpos + nsh[2:0];
          align_n  = (bitpos_n == 3'd0);
        end
      end
      S_FLUSHED: begin
        if (accept) begin
          bin_vld_n = 1'b1;
          if (flush_first) begin
            bin_n         = ivl_offset[0];
            align_n       = (bitpos == 3'd0);
            flush_first_n = 1'b0;
          end else begin
            bin_n    = bitbuf[15];
            nsh      = 4'd1;
            bitpos_n = bitpos + 3'd1;
            align_n  = (bitpos_n == 3'd0);
          end
        end
      end
      default: ;
    endcase

    // Consume first, then append the incoming byte directly below what remains
    buf_c    = bitbuf << nsh;
    cnt_c    = count - {1'b0, nsh};
    bitbuf_n = buf_c;
    count_n  = cnt_c;
    if (take_byte) begin
      bitbuf_n = buf_c | ({bs_data, 8'h00} >> cnt_c);
      count_n  = cnt_c + 5'd8;
    end

    if (arithInit) begin
      state_n       = S_LOAD;
      bitbuf_n      = '0;
      count_n       = '0;
      bitpos_n      = '0;
      flush_first_n = 1'b0;
      bin_vld_n     = 1'b0;
      upd_vld_n     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      bitbuf             <= '0;
      count              <= '0;
      bitpos             <= '0;
      ivl_range          <= '0;
      ivl_offset         <= '0;
      flush_first        <= 1'b0;
      ruiBin             <= 1'b0;
      ruiBin_vld         <= 1'b0;
      ruiBin_bytealign   <= 1'b0;
      ctxStateUpdate     <= '0;
      ctxStateUpdate_vld <= 1'b0;
    end else begin
      state              <= state_n;
      bitbuf             <= bitbuf_n;
      count              <= count_n;
      bitpos             <= bitpos_n;
      ivl_range          <= range_n;
      ivl_offset         <= offset_n;
      flush_first        <= flush_first_n;
      ruiBin             <= bin_n;
      ruiBin_vld         <= bin_vld_n;
      ruiBin_bytealign   <= align_n;
      ctxStateUpdate     <= upd_n;
      ctxStateUpdate_vld <= upd_vld_n;
    end
  end

endmodule

// File: tb/tb_qdec_arith_dec.sv
// Directed bench for qdec_arith_dec: init, context MPS/LPS, bypass, terminate + trailing bits,
// update stall, ignored requests, back-to-back bins, init/reset discard.
module tb_qdec_arith_dec;
  logic       clk = 1'b0, rst_n = 1'b0, arithInit = 1'b0, dec_run = 1'b0, EPMode = 1'b0, term_mode = 1'b0;
  logic       mps = 1'b0, ctxState_vld = 1'b0, ctxStateUpdate_rdy = 1'b1, bs_vld = 1'b0;
  logic [6:0] ctxState = '0;
  logic [7:0] bs_data = '0;
  logic       dec_rdy, ctxState_rdy, ctxStateUpdate_vld, ruiBin, ruiBin_vld, ruiBin_bytealign, bs_rdy;
  logic [6:0] ctxStateUpdate;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] feed_q[$];
  logic last_acc = 1'b0;

  qdec_arith_dec dut (
    .clk(clk), .rst_n(rst_n), .arithInit(arithInit), .dec_run(dec_run), .dec_rdy(dec_rdy),
    .EPMode(EPMode), .term_mode(term_mode), .ctxState(ctxState), .mps(mps),
    .ctxState_vld(ctxState_vld), .ctxState_rdy(ctxState_rdy), .ctxStateUpdate(ctxStateUpdate),
    .ctxStateUpdate_vld(ctxStateUpdate_vld), .ctxStateUpdate_rdy(ctxStateUpdate_rdy),
    .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld), .ruiBin_bytealign(ruiBin_bytealign),
    .bs_data(bs_data), .bs_vld(bs_vld), .bs_rdy(bs_rdy)
  );

  initial forever #5 clk = ~clk;

  // One clock: handshakes are sampled at the falling edge, the byte source advances 1 ns after the rise.
  task automatic tick();
    logic take;
    logic [7:0] dropped;
    @(negedge clk);
    take     = bs_vld && bs_rdy;
    last_acc = dec_rdy && dec_run && (term_mode || EPMode || ctxState_vld);
    @(posedge clk);
    #1;
    if (take && feed_q.size() > 0) dropped = feed_q.pop_front();
    if (feed_q.size() > 0) begin
      bs_vld  = 1'b1;
      bs_data = feed_q[0];
    end else begin
      bs_vld  = 1'b0;
      bs_data = 8'h00;
    end
  endtask

  task automatic do_init(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    feed_q.delete();
    feed_q.push_back(b0);
    feed_q.push_back(b1);
    feed_q.push_back(b2);
    arithInit = 1'b1;
    tick();
    arithInit = 1'b0;
    for (int i = 0; i < 20; i++) if (dec_rdy !== 1'b1) tick();
    n_cmp++;
    if (dec_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL init_ready_timeout: dec_rdy=%b required 1", dec_rdy);
    end
  endtask

  task automatic issue(input logic t, input logic e, input logic cv, input logic [5:0] p, input logic m);
    logic ok;
    term_mode = t; EPMode = e; ctxState_vld = cv; ctxState = {1'b1, p}; mps = m; dec_run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) if (!ok) begin
      tick();
      ok = last_acc;
    end
    dec_run = 1'b0; term_mode = 1'b0; EPMode = 1'b0; ctxState_vld = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL request_accept_timeout: accepted=%b required 1", ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({dec_rdy, ctxState_rdy, bs_rdy, ruiBin, ruiBin_vld, ruiBin_bytealign, ctxStateUpdate_vld} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b%b required 0000000", dec_rdy, ctxState_rdy, bs_rdy,
               ruiBin, ruiBin_vld, ruiBin_bytealign, ctxStateUpdate_vld);
    end
    n_cmp++;
    if (ctxStateUpdate !== 7'd0) begin
      n_err++; $display("FAIL reset_update: got %b required 0000000", ctxStateUpdate);
    end
    n_cmp++;
    if ({dut.state, dut.ivl_range, dut.ivl_offset, dut.count, dut.bitpos} !== '0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d range=%0d offset=%0d count=%0d bitpos=%0d required all 0",
               dut.state, dut.ivl_range, dut.ivl_offset, dut.count, dut.bitpos);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_init();
    do_init(8'hF0, 8'h00, 8'h00);
    n_cmp++;
    if (dut.ivl_offset !== 9'd480 || dut.ivl_range !== 9'd510 || dut.bitpos !== 3'd1) begin
      n_err++;
      $display("FAIL init_values: offset=%0d range=%0d bitpos=%0d required 480 510 1",
               dut.ivl_offset, dut.ivl_range, dut.bitpos);
    end
  endtask

  task automatic test_ctx_mps();
    do_init(8'h00, 8'h00, 8'h00);
    issue(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    n_cmp++;
    if (ruiBin_vld !== 1'b1 || ruiBin !== 1'b0 || ruiBin_bytealign !== 1'b0) begin
      n_err++;
      $display("FAIL ctx_mps_bin: vld=%b bin=%b align=%b required 1 0 0", ruiBin_vld, ruiBin, ruiBin_bytealign);
    end
    n_cmp++;
    if (ctxStateUpdate_vld !== 1'b1 || ctxStateUpdate !== 7'b0000010) begin
      n_err++;
      $display("FAIL ctx_mps_update: vld=%b upd=%b required 1 0000010", ctxStateUpdate_vld, ctxStateUpdate);
    end
    n_cmp++;
    if (dut.ivl_range !== 9'd270) begin
      n_err++; $display("FAIL ctx_mps_range: got %0d required 270", dut.ivl_range);
    end
  endtask

  task automatic test_ctx_lps();
    do_init(8'hF0, 8'h00, 8'h00);
    issue(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    n_cmp++;
    if (ruiBin_vld !== 1'b1 || ruiBin !== 1'b1) begin
      n_err++; $display("FAIL ctx_lps_bin: vld=%b bin=%b required 1 1", ruiBin_vld, ruiBin);
    end
    n_cmp++;
    if (dut.ivl_range !== 9'd480 || dut.ivl_offset !== 9'd420) begin
      n_err++;
      $display("FAIL ctx_lps_ivl: range=%0d offset=%0d required 480 420", dut.ivl_range, dut.ivl_offset);
    end
    n_cmp++;
    if (ctxStateUpdate !== 7'b0000001 || ctxStateUpdate_vld !== 1'b1) begin
      n_err++;
      $display("FAIL ctx_lps_update: vld=%b upd=%b required 1 0000001", ctxStateUpdate_vld, ctxStateUpdate);
    end
  endtask

  task automatic test_bypass();
    do_init(8'h80, 8'h00, 8'h00);
    issue(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if (ruiBin_vld !== 1'b1 || ruiBin !== 1'b1 || ctxStateUpdate_vld !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_bin: vld=%b bin=%b updvld=%b required 1 1 0", ruiBin_vld, ruiBin, ctxStateUpdate_vld);
    end
    n_cmp++;
    if (dut.ivl_offset !== 9'd2 || dut.ivl_range !== 9'd510) begin
      n_err++;
      $display("FAIL bypass_ivl: offset=%0d range=%0d required 2 510", dut.ivl_offset, dut.ivl_range);
    end
  endtask

  task automatic test_terminate();
    do_init(8'hFE, 8'h80, 8'h00);
    issue(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    n_cmp++;
    if (ruiBin !== 1'b1 || ruiBin_vld !== 1'b1 || dut.state !== 2'd3) begin
      n_err++;
      $display("FAIL term_bin: bin=%b vld=%b state=%0d required 1 1 3", ruiBin, ruiBin_vld, dut.state);
    end
    issue(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    n_cmp++;
    if (ruiBin !== 1'b1 || ruiBin_bytealign !== 1'b0 || ctxStateUpdate_vld !== 1'b0) begin
      n_err++;
      $display("FAIL stop_bit: bin=%b align=%b updvld=%b required 1 0 0", ruiBin, ruiBin_bytealign,
               ctxStateUpdate_vld);
    end
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      n_cmp++;
      if (ruiBin !== 1'b0 || ruiBin_bytealign !== (i == 6)) begin
        n_err++;
        $display("FAIL trailing_bit_%0d: bin=%b align=%b required 0 %b", i, ruiBin, ruiBin_bytealign, i == 6);
      end
    end
  endtask

  task automatic test_stall();
    do_init(8'h00, 8'h00, 8'h00);
    ctxStateUpdate_rdy = 1'b0;
    issue(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    ctxState = 7'd1; mps = 1'b0; ctxState_vld = 1'b1; dec_run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (ctxStateUpdate_vld !== 1'b1 || ctxStateUpdate !== 7'b0000010 || dec_rdy !== 1'b0 || ruiBin_vld !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold_%0d: updvld=%b upd=%b dec_rdy=%b binvld=%b required 1 0000010 0 0", k,
                 ctxStateUpdate_vld, ctxStateUpdate, dec_rdy, ruiBin_vld);
      end
    end
    ctxStateUpdate_rdy = 1'b1;
    #1;
    n_cmp++;
    if (dec_rdy !== 1'b1) begin
      n_err++; $display("FAIL stall_release: dec_rdy=%b required 1", dec_rdy);
    end
    tick();
    dec_run = 1'b0; ctxState_vld = 1'b0;
    n_cmp++;
    if (ruiBin_vld !== 1'b1 || ruiBin !== 1'b0 || ctxStateUpdate !== 7'b0000100 || dut.ivl_range !== 9'd284) begin
      n_err++;
      $display("FAIL stall_resume: vld=%b bin=%b upd=%b range=%0d required 1 0 0000100 284", ruiBin_vld,
               ruiBin, ctxStateUpdate, dut.ivl_range);
    end
  endtask

  task automatic test_ctx_ignore();
    do_init(8'h00, 8'h00, 8'h00);
    dec_run = 1'b1; ctxState_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (ruiBin_vld !== 1'b0 || dec_rdy !== 1'b1) begin
        n_err++;
        $display("FAIL ctx_invalid_ignored_%0d: binvld=%b dec_rdy=%b required 0 1", k, ruiBin_vld, dec_rdy);
      end
    end
    dec_run = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] want;
    do_init(8'h80, 8'h00, 8'h00);
    want = 3'b100;
    EPMode = 1'b1; dec_run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) begin dec_run = 1'b0; EPMode = 1'b0; end
      n_cmp++;
      if (ruiBin_vld !== 1'b1 || ruiBin !== want[2 - k]) begin
        n_err++;
        $display("FAIL b2b_bin_%0d: vld=%b bin=%b required 1 %b", k, ruiBin_vld, ruiBin, want[2 - k]);
      end
    end
    n_cmp++;
    if (dut.ivl_offset !== 9'd8 || dut.bitpos !== 3'd4) begin
      n_err++;
      $display("FAIL b2b_state: offset=%0d bitpos=%0d required 8 4", dut.ivl_offset, dut.bitpos);
    end
    tick();
    n_cmp++;
    if (ruiBin_vld !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: vld=%b required 0", ruiBin_vld);
    end
  endtask

  task automatic test_init_drop();
    do_init(8'h00, 8'h00, 8'h00);
    ctxStateUpdate_rdy = 1'b0;
    issue(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    arithInit = 1'b1;
    tick();
    arithInit = 1'b0;
    ctxStateUpdate_rdy = 1'b1;
    n_cmp++;
    if (ctxStateUpdate_vld !== 1'b0 || ruiBin_vld !== 1'b0 || dut.state !== 2'd1 || dut.count !== 5'd0) begin
      n_err++;
      $display("FAIL init_drop: updvld=%b binvld=%b state=%0d count=%0d required 0 0 1 0",
               ctxStateUpdate_vld, ruiBin_vld, dut.state, dut.count);
    end
  endtask

  task automatic test_reset_mid();
    do_init(8'h80, 8'h00, 8'h00);
    EPMode = 1'b1; dec_run = 1'b1; rst_n = 1'b0;
    tick();
    dec_run = 1'b0; EPMode = 1'b0;
    n_cmp++;
    if (ruiBin_vld !== 1'b0 || dut.state !== 2'd0 || dec_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: binvld=%b state=%0d dec_rdy=%b required 0 0 0", ruiBin_vld, dut.state, dec_rdy);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (ruiBin_vld !== 1'b0) begin
      n_err++; $display("FAIL reset_after: binvld=%b required 0", ruiBin_vld);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_ctx_mps();
    test_ctx_lps();
    test_bypass();
    test_terminate();
    test_stall();
    test_ctx_ignore();
    test_back_to_back();
    test_init_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/qdec_arith_dec.md
QDEC_ARITH_DEC -- requirements
Module: qdec_arith_dec

Interface
REQ-001 SHALL have ports: clk in 1 (clock); rst_n in 1 (reset, synchronous, active-low); clock clk.
REQ-002 SHALL have ports: arithInit in 1 (engine init request); dec_run in 1 (bin request); dec_rdy out 1 (engine can accept bin); EPMode in 1 (bypass bin); term_mode in 1 (terminate bin, priority over EPMode).
REQ-003 SHALL have ports: ctxState in 7 (bits[5:0] pStateIdx, bit6 ignored); mps in 1 (valMps); ctxState_vld in 1; ctxState_rdy out 1 (= dec_rdy).
REQ-004 SHALL have ports: ctxStateUpdate out 7 ({pStateIdx_new[5:0], valMps_new}); ctxStateUpdate_vld out 1; ctxStateUpdate_rdy in 1.
REQ-005 SHALL have ports: ruiBin out 1; ruiBin_vld out 1 (1-cycle pulse); ruiBin_bytealign out 1 (valid with ruiBin_vld).
REQ-006 SHALL have ports: bs_data in 8 (RBSP byte, emulation prevention already removed upstream, MSB first); bs_vld in 1; bs_rdy out 1.

Function
REQ-007 SHALL implement states IDLE, LOAD, RUN, FLUSHED; arithInit=1 in any state -> LOAD next cycle, bit buffer/count/bitpos cleared, pending outputs dropped.
REQ-008 SHALL hold a 16-bit bit buffer with 5-bit count; bs_rdy=1 when state!=IDLE, arithInit=0, count<=8; byte accepted on bs_vld&bs_rdy appended below existing bits, count+=8.
REQ-009 LOAD: when count>=9, ivlOffset=first 9 bits, ivlCurrRange=510, count-=9, bitpos=(bitpos+9) mod 8, -> RUN.
REQ-010 dec_rdy=1 only in RUN or FLUSHED, arithInit=0, count>=8, no update stalled (REQ-016).
REQ-011 Request accepted when dec_rdy & dec_run & (term_mode | EPMode | ctxState_vld); otherwise no state change.
REQ-012 Context bin: q=range[7:6]; rLps=rangeTabLps[p][q]; range-=rLps; offset>=range -> bin=!mps, offset-=range, range=rLps, mps flips if p==0, p=transIdxLps[p]; else bin=mps, p=min(p+1,62).
REQ-013 Bypass bin: offset=(offset<<1)|nextbit; offset>=range -> bin=1, offset-=range; else bin=0; range unchanged.
REQ-014 Terminate bin: range-=2; offset>=range -> bin=1, no renorm, -> FLUSHED; else bin=0, renorm.
REQ-015 Renorm in same cycle as decision: shift n=leading-zero count so range>=256 (n<=6), offset shifted in n buffer bits, count-=n, bitpos+=n mod 8.
REQ-016 Outputs registered: ruiBin/ruiBin_vld one cycle after acceptance; throughput 1 bin/cycle; ctxStateUpdate_vld with ruiBin_vld for context bins only, held until ctxStateUpdate_rdy, dec_rdy=0 while held.
REQ-017 FLUSHED: first accepted request returns ruiBin=ivlOffset[0] (rbsp_stop_one_bit) with bytealign=(bitpos==0); later requests return next raw buffer bit, bitpos+=1, bytealign=1 when bitpos becomes 0; all requests treated raw regardless of mode.
REQ-018 ruiBin_bytealign in RUN SHALL equal (bitpos==0) after the bin.
REQ-019 rangeTabLps (64x4) and transIdxLps (64) SHALL be per HEVC Tables 9-46/9-47; pStateIdx>62 treated as 62.
REQ-020 dec_run with ctxState_vld=0 (context mode) SHALL be ignored without stalling.

Reset
REQ-021 rst_n=0: state IDLE; range=0, offset=0, count=0, bitpos=0; dec_rdy, ctxState_rdy, bs_rdy, ruiBin, ruiBin_vld, ruiBin_bytealign, ctxStateUpdate, ctxStateUpdate_vld all 0.
REQ-022 Reset mid-bin SHALL discard the in-flight bin; no ruiBin_vld after reset.

Verification
REQ-023 Init: arithInit pulse, bytes 0xF0,0x00 -> offset=480, range=510, dec_rdy=1, bitpos=1.
REQ-024 Context MPS: bytes 0x00,0x00, p=0 mps=0 -> ruiBin=0, ctxStateUpdate=7'b0000010, range=270.
REQ-025 Context LPS: bytes 0xF0,0x00, p=0 mps=0 -> ruiBin=1, range=480, offset=420, ctxStateUpdate=7'b0000001.
REQ-026 Bypass: bytes 0x80,0x00 -> ruiBin=1, offset=2.
REQ-027 Terminate+trailing: bytes 0xFE,0x80, term_mode -> ruiBin=1, FLUSHED; next request ruiBin=1 bytealign=0; 7 raw requests ruiBin=0, bytealign=1 only on 7th.
REQ-028 Stall: ctxStateUpdate_rdy=0 for 3 cycles after context bin -> update held stable, dec_rdy=0, resumes on rdy=1.
